// File: rtl/highscore_table.sv
// Sorted top-ENTRIES score table with a serial binary-to-BCD converter for the score display.
// One score per insert: compare, shift into place, then shift-add-3 one bit per cycle.
module highscore_table #(
  parameter int ENTRIES = 4,
  parameter int SCORE_W = 14
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               points_calculated,
  input  logic [SCORE_W-1:0] points,
  input  logic               clear_table,
  input  logic [2:0]         rank_rd_idx,
  output logic [SCORE_W-1:0] rank_rd_score,
  output logic [2:0]         new_rank,
  output logic [19:0]        bcd_score,
  output logic               busy,
  output logic               insert_done
);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_COMPARE = 3'd1;
  localparam logic [2:0] S_SHIFT   = 3'd2;
  localparam logic [2:0] S_CONVERT = 3'd3;
  localparam logic [2:0] S_DONE    = 3'd4;
  localparam int         CNT_W     = (SCORE_W > 1) ? $clog2(SCORE_W) : 1;
  localparam logic [2:0] ENT3      = 3'(ENTRIES);

  logic [2:0]                      state_q, state_d;
  logic [SCORE_W-1:0]              score_q, score_d;
  logic [2:0]                      pos_q, pos_d, pos_c;
  logic [ENTRIES-1:0][SCORE_W-1:0] slot_q, slot_d, slot_sh;
  logic [CNT_W-1:0]                cnt_q, cnt_d;
  logic [SCORE_W-1:0]              sh_q, sh_d;
  logic [19:0]                     dd_q, dd_d, dd_adj, dd_shift;
  logic [2:0]                      new_rank_q, new_rank_d;
  logic [19:0]                     bcd_q, bcd_d;
  logic                            ins_q, ins_d;
  logic [SCORE_W-1:0]              rd_q, rd_d;

  // Lowest slot strictly below the new score; ties land underneath existing entries.
  always_comb begin
    pos_c = ENT3;
    for (int i = ENTRIES - 1; i >= 0; i--)
      if (score_q > slot_q[i]) pos_c = 3'(i);
  end

  always_comb begin
    slot_sh = slot_q;
    for (int j = ENTRIES - 1; j > 0; j--)
      if (3'(j) > pos_q) slot_sh[j] = slot_q[j-1];
    for (int j = 0; j < ENTRIES; j++)
      if (3'(j) == pos_q) slot_sh[j] = score_q;
  end

  for (genvar g = 0; g < 5; g++) begin : g_dig
    assign dd_adj[4*g +: 4] = (dd_q[4*g +: 4] >= 4'd5) ? dd_q[4*g +: 4] + 4'd3 : dd_q[4*g +: 4];
  end
  assign dd_shift = {dd_adj[18:0], sh_q[SCORE_W-1]};

  always_comb begin
    rd_d = '0;
    for (int i = 0; i < ENTRIES; i++)
      if (rank_rd_idx == 3'(i)) rd_d = slot_q[i];
  end

  always_comb begin
    state_d    = state_q;
    score_d    = score_q;
    pos_d      = pos_q;
    slot_d     = slot_q;
    cnt_d      = cnt_q;
    sh_d       = sh_q;
    dd_d       = dd_q;
    new_rank_d = new_rank_q;
    bcd_d      = bcd_q;
    ins_d      = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (clear_table) begin
          slot_d     = '0;
          new_rank_d = '0;
        end else if (points_calculated) begin
          score_d = points;
          state_d = S_COMPARE;
        end
      end
      S_COMPARE: begin
        pos_d   = pos_c;
        state_d = S_SHIFT;
      end
      S_SHIFT: begin
        slot_d     = slot_sh;
        new_rank_d = (pos_q < ENT3) ? pos_q + 3'd1 : 3'd0;
        sh_d       = score_q;
        dd_d       = '0;
        cnt_d      = '0;
        state_d    = S_CONVERT;
      end
      S_CONVERT: begin
        sh_d  = {sh_q[SCORE_W-2:0], 1'b0};
        dd_d  = dd_shift;
        cnt_d = cnt_q + CNT_W'(1);
        // Result and done pulse are registered together so they appear in the DONE cycle.
        if (cnt_q == CNT_W'(SCORE_W - 1)) begin
          bcd_d   = dd_shift;
          ins_d   = 1'b1;
          state_d = S_DONE;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= S_IDLE;
      score_q    <= '0;
      pos_q      <= '0;
      slot_q     <= '0;
      cnt_q      <= '0;
      sh_q       <= '0;
      dd_q       <= '0;
      new_rank_q <= '0;
      bcd_q      <= '0;
      ins_q      <= 1'b0;
      rd_q       <= '0;
    end else begin
      state_q    <= state_d;
      score_q    <= score_d;
      pos_q      <= pos_d;
      slot_q     <= slot_d;
      cnt_q      <= cnt_d;
      sh_q       <= sh_d;
      dd_q       <= dd_d;
      new_rank_q <= new_rank_d;
      bcd_q      <= bcd_d;
      ins_q      <= ins_d;
      rd_q       <= rd_d;
    end
  end

  assign rank_rd_score = rd_q;
  assign new_rank      = new_rank_q;
  assign bcd_score     = bcd_q;
  assign busy          = (state_q != S_IDLE);
  assign insert_done   = ins_q;

endmodule

// File: tb/tb_highscore_table.sv
// Bench for highscore_table: directed vector table, multi-cycle corner sequences,
// and random inserts checked against a queue-based sorted-table model.
module tb_highscore_table;

  logic        clk = 1'b0;
  logic        rst;
  logic        points_calculated;
  logic [13:0] points;
  logic        clear_table;
  logic [2:0]  rank_rd_idx;
  logic [13:0] rank_rd_score;
  logic [2:0]  new_rank;
  logic [19:0] bcd_score;
  logic        busy;
  logic        insert_done;

  int n_tests = 0;
  int n_fail  = 0;
  int mdl[$];

  highscore_table #(.ENTRIES(4), .SCORE_W(14)) dut (
    .clk(clk), .rst(rst), .points_calculated(points_calculated), .points(points),
    .clear_table(clear_table), .rank_rd_idx(rank_rd_idx), .rank_rd_score(rank_rd_score),
    .new_rank(new_rank), .bcd_score(bcd_score), .busy(busy), .insert_done(insert_done)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic [13:0]      pts;
    logic [2:0]       rank;
    logic [19:0]      bcd;
    logic [3:0][13:0] tbl;
  } vec_t;

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0d (0x%0h) exp=%0d (0x%0h)", nm, got, got, exp, exp);
    end
  endtask

  function automatic logic [19:0] bcd_of(input int v);
    logic [19:0] r = '0;
    int div = 1;
    for (int d = 0; d < 5; d++) begin
      r[4*d +: 4] = 4'((v / div) % 10);
      div = div * 10;
    end
    return r;
  endfunction

  // Sorted-table model: position = number of entries >= score (ties go below).
  function automatic int model_insert(input int s);
    int pos = 0;
    foreach (mdl[i]) if (mdl[i] >= s) pos++;
    if (pos >= 4) return 0;
    mdl.insert(pos, s);
    void'(mdl.pop_back());
    return pos + 1;
  endfunction

  task automatic rd(input int i, output logic [13:0] v);
    @(negedge clk);
    rank_rd_idx = 3'(i);
    @(negedge clk);
    v = rank_rd_score;
  endtask

  task automatic do_insert(input logic [13:0] p, output int lat,
                           output logic [2:0] rk, output logic [19:0] bcd);
    int n = 0;
    @(negedge clk);
    points = p;
    points_calculated = 1'b1;
    do begin
      @(negedge clk);
      points_calculated = 1'b0;
      n++;
    end while (!insert_done && n < 40);
    lat = n;
    rk  = new_rank;
    bcd = bcd_score;
    @(negedge clk);
    chk("done_one_cycle", {31'd0, insert_done}, 32'd0);
    chk("idle_after_done", {31'd0, busy}, 32'd0);
  endtask

  task automatic chk_table(input string nm, input logic [3:0][13:0] exp);
    logic [13:0] v;
    for (int i = 0; i < 4; i++) begin
      rd(i, v);
      chk($sformatf("%s_slot%0d", nm, i), {18'd0, v}, {18'd0, exp[i]});
    end
  endtask

  initial begin
    vec_t        vecs[7];
    int          lat, hits, bhits, n;
    logic [2:0]  rk;
    logic [19:0] bcd;
    logic [13:0] v, p;
    logic [3:0][13:0] etbl;

    vecs[0] = '{14'd5000,  3'd1, 20'h05000, {14'd0,    14'd0,    14'd0,    14'd5000}};
    vecs[1] = '{14'd7000,  3'd1, 20'h07000, {14'd0,    14'd0,    14'd5000, 14'd7000}};
    vecs[2] = '{14'd3000,  3'd3, 20'h03000, {14'd0,    14'd3000, 14'd5000, 14'd7000}};
    vecs[3] = '{14'd6000,  3'd2, 20'h06000, {14'd3000, 14'd5000, 14'd6000, 14'd7000}};
    vecs[4] = '{14'd5000,  3'd4, 20'h05000, {14'd5000, 14'd5000, 14'd6000, 14'd7000}};
    vecs[5] = '{14'd1000,  3'd0, 20'h01000, {14'd5000, 14'd5000, 14'd6000, 14'd7000}};
    vecs[6] = '{14'd16383, 3'd1, 20'h16383, {14'd5000, 14'd6000, 14'd7000, 14'd16383}};

    rst = 1'b0; points_calculated = 1'b0; clear_table = 1'b0; points = '0; rank_rd_idx = '0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    chk("rst_new_rank", {29'd0, new_rank}, 32'd0);
    chk("rst_bcd", {12'd0, bcd_score}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, insert_done}, 32'd0);
    chk("rst_rd", {18'd0, rank_rd_score}, 32'd0);
    chk_table("rst", '0);

    foreach (vecs[k]) begin
      do_insert(vecs[k].pts, lat, rk, bcd);
      chk($sformatf("vec%0d_latency", k), lat, 32'd17);
      chk($sformatf("vec%0d_rank", k), {29'd0, rk}, {29'd0, vecs[k].rank});
      chk($sformatf("vec%0d_bcd", k), {12'd0, bcd}, {12'd0, vecs[k].bcd});
      chk_table($sformatf("vec%0d", k), vecs[k].tbl);
    end

    for (int i = 4; i < 8; i++) begin
      rd(i, v);
      chk($sformatf("rd_oob%0d", i), {18'd0, v}, 32'd0);
    end

    // Read during SHIFT sees pre-shift data; pulse/clear while busy are ignored.
    @(negedge clk);
    rank_rd_idx = 3'd1;
    points = 14'd16000;
    points_calculated = 1'b1;
    n = 0;
    do begin
      @(negedge clk);
      n++;
      if (n == 1) points_calculated = 1'b0;
      if (n == 3) chk("rd_in_shift_pre", {18'd0, rank_rd_score}, 32'd7000);
      if (n == 4) chk("rd_after_shift", {18'd0, rank_rd_score}, 32'd16000);
      if (n == 5) begin points = 14'd9999; points_calculated = 1'b1; clear_table = 1'b1; end
      if (n == 6) begin points_calculated = 1'b0; clear_table = 1'b0; end
    end while (!insert_done && n < 40);
    chk("busy_seq_latency", n, 32'd17);
    chk("busy_seq_rank", {29'd0, new_rank}, 32'd2);
    hits = 0;
    repeat (25) begin @(negedge clk); if (insert_done) hits++; end
    chk("busy_pulse_ignored", hits, 32'd0);
    chk_table("busy_seq", {14'd6000, 14'd7000, 14'd16000, 14'd16383});

    // Clear wins over a simultaneous pulse.
    @(negedge clk);
    clear_table = 1'b1; points_calculated = 1'b1; points = 14'd1234;
    @(negedge clk);
    clear_table = 1'b0; points_calculated = 1'b0;
    hits = 0; bhits = 0;
    repeat (25) begin @(negedge clk); if (insert_done) hits++; if (busy) bhits++; end
    chk("clear_no_done", hits, 32'd0);
    chk("clear_no_busy", bhits, 32'd0);
    chk("clear_new_rank", {29'd0, new_rank}, 32'd0);
    chk_table("clear", '0);

    // Reset in the middle of CONVERT.
    do_insert(14'd4321, lat, rk, bcd);
    chk("pre_rst_rank", {29'd0, rk}, 32'd1);
    @(negedge clk);
    rank_rd_idx = 3'd0;
    points = 14'd8000;
    points_calculated = 1'b1;
    hits = 0;
    for (int c = 1; c <= 30; c++) begin
      @(negedge clk);
      if (c == 1) points_calculated = 1'b0;
      if (c == 6) rst = 1'b0;
      if (c == 7) begin
        rst = 1'b1;
        chk("midrst_busy", {31'd0, busy}, 32'd0);
        chk("midrst_rank", {29'd0, new_rank}, 32'd0);
        chk("midrst_bcd", {12'd0, bcd_score}, 32'd0);
        chk("midrst_rd", {18'd0, rank_rd_score}, 32'd0);
      end
      if (insert_done) hits++;
    end
    chk("midrst_no_done", hits, 32'd0);
    chk_table("midrst", '0);

    // Random inserts against the model, starting from the empty table.
    mdl = '{0, 0, 0, 0};
    for (int it = 0; it < 40; it++) begin
      int sel, erk;
      sel = $urandom_range(0, 9);
      if (sel == 0)     p = 14'd0;
      else if (sel < 3) p = 14'(mdl[$urandom_range(0, 3)]);
      else              p = 14'($urandom_range(1, 16383));
      erk = model_insert(int'(p));
      do_insert(p, lat, rk, bcd);
      chk($sformatf("rnd%0d_latency", it), lat, 32'd17);
      chk($sformatf("rnd%0d_rank", it), {29'd0, rk}, erk);
      chk($sformatf("rnd%0d_bcd", it), {12'd0, bcd}, {12'd0, bcd_of(int'(p))});
      for (int i = 0; i < 4; i++) etbl[i] = 14'(mdl[i]);
      chk_table($sformatf("rnd%0d", it), etbl);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
